// File: rtl/game_state_ctrl.sv
// Game sequencer: derives the per-frame tick from vblank and walks the
// menu -> countdown -> playing -> result -> menu round flow.
module game_state_ctrl #(
    parameter int CHAR_HP_INIT       = 10,
    parameter int START_DELAY_FRAMES = 60,
    parameter int END_HOLD_FRAMES    = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       start_btn,
    input  logic [3:0] player_hp,
    input  logic [3:0] player2_hp,
    input  logic       player2_present,
    input  logic [7:0] boss_hp,
    output logic       frame_tick,
    output logic       game_start,
    output logic [1:0] game_active,
    output logic [3:0] char_hp,
    output logic [7:0] count_val
);

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAYING   = 3'd2,
        LOST      = 3'd3,
        WON       = 3'd4
    } state_t;

    localparam logic [7:0] START_LOAD = 8'(START_DELAY_FRAMES);
    localparam logic [7:0] HOLD_LOAD  = 8'(END_HOLD_FRAMES);

    state_t     state;
    state_t     next_state;
    logic [7:0] counter;
    logic [7:0] counter_next;

    logic       vblnk_q;
    logic       btn_q;
    logic       start_rise;
    logic       lose_cond;
    logic       win_cond;

    logic       game_start_next;
    logic [1:0] game_active_next;
    logic [7:0] count_val_next;

    assign char_hp = 4'(CHAR_HP_INIT);

    // History regs reset high so a level already present at reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q    <= 1'b1;
            btn_q      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vblnk_q    <= vblnk;
            btn_q      <= start_btn;
            frame_tick <= vblnk & ~vblnk_q;
        end
    end

    assign start_rise = start_btn & ~btn_q;
    assign lose_cond  = (player_hp == 4'd0) && (!player2_present || (player2_hp == 4'd0));
    assign win_cond   = (boss_hp == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MENU;
            counter <= 8'd0;
        end else begin
            state   <= next_state;
            counter <= counter_next;
        end
    end

    // A counter of 0 or 1 both end the phase, so the counter never underflows.
    always_comb begin
        next_state   = state;
        counter_next = counter;
        case (state)
            MENU: begin
                counter_next = 8'd0;
                if (start_rise) begin
                    next_state   = COUNTDOWN;
                    counter_next = START_LOAD;
                end
            end
            COUNTDOWN: begin
                if (frame_tick) begin
                    if (counter <= 8'd1) begin
                        next_state   = PLAYING;
                        counter_next = 8'd0;
                    end else begin
                        counter_next = counter - 8'd1;
                    end
                end
            end
            PLAYING: begin
                counter_next = 8'd0;
                if (frame_tick) begin
                    if (lose_cond) begin
                        next_state   = LOST;
                        counter_next = HOLD_LOAD;
                    end else if (win_cond) begin
                        next_state   = WON;
                        counter_next = HOLD_LOAD;
                    end
                end
            end
            LOST, WON: begin
                if (frame_tick) begin
                    if (counter <= 8'd1) begin
                        next_state   = MENU;
                        counter_next = 8'd0;
                    end else begin
                        counter_next = counter - 8'd1;
                    end
                end
            end
            default: begin
                next_state   = MENU;
                counter_next = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track the state register.
    always_comb begin
        game_start_next  = 1'b0;
        game_active_next = 2'd0;
        count_val_next   = 8'd0;
        if (state == MENU && start_rise) begin
            game_start_next = 1'b1;
        end
        case (next_state)
            COUNTDOWN: count_val_next = counter_next;
            PLAYING:   game_active_next = 2'd1;
            LOST: begin
                game_active_next = 2'd2;
                count_val_next   = counter_next;
            end
            WON: begin
                game_active_next = 2'd3;
                count_val_next   = counter_next;
            end
            default: begin
                game_active_next = 2'd0;
                count_val_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_start  <= 1'b0;
            game_active <= 2'd0;
            count_val   <= 8'd0;
        end else begin
            game_start  <= game_start_next;
            game_active <= game_active_next;
            count_val   <= count_val_next;
        end
    end

endmodule
